mul_seq: RTL and testbench

Iterative radix-2 shift-add multiplier for the EX stage, the multiply-side counterpart of the non-restoring array divider. Executes RV32M MUL/MULH/MULHSU/MULHU on two XLEN-bit operands over XLEN+1 cycles, one partial-product add per cycle. Sits beside the divider behind the EX unit's start/valid handshake. It holds the pipeline via `busy_o` and returns one result pulse per accepted operation.

---
 rtl/mul_seq.sv | 117 +++++++++++
 tb/tb_mul_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes over XLEN cycles, then applies the sign in one fix-up cycle.
module mul_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_a_mag;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_neg;
   logic [1:0]        r_op;
   logic              r_valid;
   logic [XLEN-1:0]   r_result;

   logic              w_sign1;
   logic              w_sign2;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic [XLEN-1:0]   w_addend;
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_p;

   // An operand counts as negative only when the selected op treats it as signed.
   assign w_sign1  = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && op1_i[XLEN-1];
   assign w_sign2  = (op_i == OP_MULH) && op2_i[XLEN-1];
   assign w_a_mag  = w_sign1 ? -op1_i : op1_i;
   assign w_b_mag  = w_sign2 ? -op2_i : op2_i;

   assign w_addend = r_acc[0] ? r_a_mag : '0;
   assign w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
   assign w_p      = r_neg ? -r_acc : r_acc;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_state_next = S_CALC;
         S_CALC:  if (r_cnt == CNT_LAST) w_state_next = S_FIX;
         S_FIX:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_a_mag  <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_op     <= 2'b00;
         r_valid  <= 1'b0;
         r_result <= '0;
      end else if (flush_i) begin
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_a_mag <= w_a_mag;
                  r_acc   <= {{XLEN{1'b0}}, w_b_mag};
                  r_cnt   <= '0;
                  r_neg   <= w_sign1 ^ w_sign2;
                  r_op    <= op_i;
               end
            end
            S_CALC: begin
               // Shift right keeping the carry out of the partial-product add.
               r_acc <= {w_sum, r_acc[XLEN-1:1]};
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               r_result <= (r_op == OP_MUL) ? w_p[XLEN-1:0] : w_p[2*XLEN-1:XLEN];
               r_valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy_o   = (r_state != S_IDLE);
   assign valid_o  = r_valid;
   assign result_o = r_result;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed RV32M cases, handshake, flush, reset
// and randomized operations against a 64-bit arithmetic reference.
module tb_mul_seq;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] op1_i;
   logic [31:0] op2_i;
   logic        flush_i;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;

   int n_err = 0;
   int n_chk = 0;

   mul_seq #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .op_i     (op_i),
      .op1_i    (op1_i),
      .op2_i    (op2_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .valid_o  (valid_o),
      .result_o (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: full 64-bit product of the properly extended operands.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for valid_o with a bound; returns edges elapsed since the accept edge.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (cycles < 100) begin
         tick();
         cycles++;
         if (valid_o) break;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int cyc;
      start_i = 1'b1; op_i = op; op1_i = a; op2_i = b;
      tick();
      start_i = 1'b0; op1_i = $urandom; op2_i = $urandom; op_i = 2'($urandom);
      wait_valid(cyc);
      check({tag, "_lat"}, 32'(cyc), 32'd33);
      check(tag, result_o, exp);
      $display("op=%0d a=0x%08h b=0x%08h -> 0x%08h (exp 0x%08h) lat=%0d",
               op, a, b, result_o, exp, cyc);
      tick();
      check({tag, "_pulse"}, {31'b0, valid_o}, 32'd0);
   endtask

   initial begin
      int cyc;
      logic [31:0] held, ra, rb, na, nb;
      logic [1:0]  rop, nop;
      int seen;

      rst = 1'b1; start_i = 1'b0; op_i = 2'b00; op1_i = '0; op2_i = '0; flush_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_result", result_o, 32'd0);

      run_op("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
      run_op("mulh_m1x7", 2'b01, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF);
      run_op("mul_m3x5", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1);
      run_op("mulhsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("mulhsu_2x", 2'b10, 32'h00000002, 32'h80000000, 32'h00000001);
      for (int k = 0; k < 4; k++) begin
         run_op("zero", 2'(k), 32'h0, $urandom | 32'h80000001, 32'h0);
      end

      // start_i held high with operands churning; only the first op completes.
      ra = $urandom; rb = $urandom; rop = 2'($urandom);
      start_i = 1'b1; op_i = rop; op1_i = ra; op2_i = rb;
      tick();
      cyc = 0;
      while (!valid_o && cyc < 100) begin
         op_i = 2'($urandom); op1_i = $urandom; op2_i = $urandom;
         tick();
         cyc++;
      end
      check("hold_lat", 32'(cyc), 32'd33);
      check("hold_first", result_o, ref_mul(rop, ra, rb));
      na = $urandom; nb = $urandom; nop = 2'($urandom);
      op_i = nop; op1_i = na; op2_i = nb;
      tick();
      start_i = 1'b0;
      check("hold_busy2", {31'b0, busy_o}, 32'd1);
      wait_valid(cyc);
      check("hold_lat2", 32'(cyc), 32'd33);
      check("hold_second", result_o, ref_mul(nop, na, nb));
      tick();

      // Flush at CALC iteration 10.
      held = result_o;
      start_i = 1'b1; op_i = 2'b11; op1_i = 32'h12345678; op2_i = 32'h9ABCDEF0;
      tick();
      start_i = 1'b0;
      repeat (9) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_busy", {31'b0, busy_o}, 32'd0);
      check("flush_valid", {31'b0, valid_o}, 32'd0);
      check("flush_result", result_o, held);
      tick();
      run_op("after_flush", 2'b01, 32'h12345678, 32'hF0000001,
             ref_mul(2'b01, 32'h12345678, 32'hF0000001));
      seen = 0;
      start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; op1_i = 32'd3; op2_i = 32'd4;
      tick();
      start_i = 1'b0; flush_i = 1'b0;
      check("start_flush_busy", {31'b0, busy_o}, 32'd0);

      // Reset held two cycles mid-CALC.
      start_i = 1'b1; op_i = 2'b11; op1_i = 32'hDEADBEEF; op2_i = 32'hCAFEF00D;
      tick();
      start_i = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("midrst_busy", {31'b0, busy_o}, 32'd0);
      check("midrst_valid", {31'b0, valid_o}, 32'd0);
      check("midrst_result", result_o, 32'd0);
      repeat (40) begin
         tick();
         if (valid_o) seen++;
      end
      check("midrst_nopulse", 32'(seen), 32'd0);

      // Randomized operations, with corner operands mixed in.
      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom);
         case ($urandom_range(0, 3))
            0: ra = 32'h80000000;
            1: ra = 32'hFFFFFFFF;
            default: ra = $urandom;
         endcase
         rb = (i % 5 == 0) ? 32'h80000000 : $urandom;
         run_op("rand", rop, ra, rb, ref_mul(rop, ra, rb));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
